// File: rtl/rename_pkg.sv
// Shared rename-stage constants and types.
// Used by the free list and the rename table.
package rename_pkg;

    localparam int PHYS_REGS = 128;
    localparam int ARCH_REGS = 32;
    localparam int PADDR_W   = 7;

    localparam int AADDR_W     = 5;
    localparam int RAT_ENTRIES = ARCH_REGS;
    localparam int RAT_CKPTS   = 1;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } fl_state_t;

endpackage

// File: rtl/free_list_ram.sv
// Free-list storage: one write port, one async read port.
// Contents are not reset; the owner rewrites them after reset.
module free_list_ram #(
    parameter int DEPTH = 128,
    parameter int WIDTH = 7,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Single synchronous write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/free_list.sv
// Physical-register free list: circular buffer with
// wrap-bit pointers, single-level head checkpoint.
module free_list
    import rename_pkg::*;
#(
    parameter int PHYS_REGS = rename_pkg::PHYS_REGS,
    parameter int ARCH_REGS = rename_pkg::ARCH_REGS,
    parameter int PADDR_W   = rename_pkg::PADDR_W
) (
    input  logic               clk,
    input  logic               reset,
    output logic               init_done,
    input  logic               alloc_req,
    output logic               alloc_valid,
    output logic [PADDR_W-1:0] alloc_addr,
    input  logic               rel_valid,
    input  logic [PADDR_W-1:0] rel_addr,
    input  logic               ckpt,
    input  logic               restore,
    output logic [PADDR_W:0]   free_count,
    output logic               err
);

    localparam int INIT_CNT = PHYS_REGS - ARCH_REGS;
    localparam int PTR_W    = PADDR_W + 1;

    fl_state_t          state;
    logic [PADDR_W-1:0] idx;
    logic [PTR_W-1:0]   head;
    logic [PTR_W-1:0]   tail;
    logic [PTR_W-1:0]   snap;
    logic [PTR_W-1:0]   head_nxt;
    logic [PTR_W-1:0]   tail_nxt;

    logic rel_live;
    logic full;
    logic pop;
    logic push;
    logic err_set;

    logic               ram_we;
    logic [PADDR_W-1:0] ram_waddr;
    logic [PADDR_W-1:0] ram_wdata;
    logic [PADDR_W-1:0] ram_rdata;

    assign alloc_valid = init_done && (free_count != '0);
    assign alloc_addr  = ram_rdata;

    // Decode this cycle's pop/push and next pointers.
    always_comb begin
        rel_live = rel_valid && (rel_addr != '0);
        full     = (free_count == PTR_W'(PHYS_REGS));
        pop      = (state == RUN) && alloc_req
                   && alloc_valid && !restore;
        push     = (state == RUN) && rel_live && !full;
        head_nxt = restore ? snap : head + PTR_W'(pop);
        tail_nxt = tail + PTR_W'(push);
        err_set  = 1'b0;
        if (state == INIT) begin
            err_set = alloc_req || rel_valid
                      || ckpt || restore;
        end else begin
            err_set = rel_live && full;
        end
    end

    // Storage write: identity fill during INIT, releases in RUN.
    always_comb begin
        ram_we    = push;
        ram_waddr = tail[PADDR_W-1:0];
        ram_wdata = rel_addr;
        if (state == INIT) begin
            ram_we    = 1'b1;
            ram_waddr = idx;
            ram_wdata = PADDR_W'(ARCH_REGS) + idx;
        end
    end

    // FSM, pointers, snapshot, count and sticky error.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= INIT;
            idx        <= '0;
            head       <= '0;
            tail       <= '0;
            snap       <= '0;
            free_count <= '0;
            init_done  <= 1'b0;
            err        <= 1'b0;
        end else begin
            if (err_set) begin
                err <= 1'b1;
            end
            unique case (state)
                INIT: begin
                    idx <= idx + PADDR_W'(1);
                    if (idx == PADDR_W'(INIT_CNT - 1)) begin
                        state      <= RUN;
                        init_done  <= 1'b1;
                        head       <= '0;
                        tail       <= PTR_W'(INIT_CNT);
                        snap       <= '0;
                        free_count <= PTR_W'(INIT_CNT);
                    end
                end
                RUN: begin
                    head       <= head_nxt;
                    tail       <= tail_nxt;
                    free_count <= tail_nxt - head_nxt;
                    if (ckpt && !restore) begin
                        snap <= head_nxt;
                    end
                end
            endcase
        end
    end

    free_list_ram #(
        .DEPTH(PHYS_REGS),
        .WIDTH(PADDR_W),
        .AW   (PADDR_W)
    ) u_ram (
        .clk  (clk),
        .we   (ram_we),
        .waddr(ram_waddr),
        .wdata(ram_wdata),
        .raddr(head[PADDR_W-1:0]),
        .rdata(ram_rdata)
    );

endmodule

// File: tb/tb_free_list.sv
// Free-list bench: queue-based reference model,
// scoreboarded per-cycle outputs plus directed checks.
module tb_free_list;
    import rename_pkg::*;

    localparam int INIT_CNT = PHYS_REGS - ARCH_REGS;

    logic               clk = 1'b0;
    logic               reset;
    logic               init_done;
    logic               alloc_req;
    logic               alloc_valid;
    logic [PADDR_W-1:0] alloc_addr;
    logic               rel_valid;
    logic [PADDR_W-1:0] rel_addr;
    logic               ckpt;
    logic               restore;
    logic [PADDR_W:0]   free_count;
    logic               err;

    free_list dut (
        .clk        (clk),
        .reset      (reset),
        .init_done  (init_done),
        .alloc_req  (alloc_req),
        .alloc_valid(alloc_valid),
        .alloc_addr (alloc_addr),
        .rel_valid  (rel_valid),
        .rel_addr   (rel_addr),
        .ckpt       (ckpt),
        .restore    (restore),
        .free_count (free_count),
        .err        (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit done;
        bit valid;
        int addr;
        int count;
        bit err;
    } exp_t;

    exp_t exp_q[$];

    // Reference model: free addresses in grant order, plus the
    // addresses handed out since the last checkpoint.
    int fq[$];
    int since[$];
    bit m_run;
    bit m_err;
    bit dirty;
    int init_left;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input int act,
                       input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d",
                     name, act, req);
        end
    endtask

    task automatic m_reset();
        fq.delete();
        since.delete();
        m_run     = 1'b0;
        m_err     = 1'b0;
        dirty     = 1'b0;
        init_left = INIT_CNT;
    endtask

    // Drive one cycle of stimulus now and queue the outputs
    // expected after the next rising edge.
    task automatic step_now(input bit a, input bit rv,
                            input int ra, input bit ck,
                            input bit rs);
        exp_t e;
        bit   can_pop;
        bit   is_full;
        alloc_req = a;
        rel_valid = rv;
        rel_addr  = PADDR_W'(ra);
        ckpt      = ck;
        restore   = rs;
        if (!m_run) begin
            if (a || rv || ck || rs) m_err = 1'b1;
            init_left--;
            if (init_left == 0) begin
                m_run = 1'b1;
                for (int i = ARCH_REGS; i < PHYS_REGS; i++)
                    fq.push_back(i);
            end
        end else begin
            can_pop = a && (fq.size() != 0) && !rs;
            is_full = (fq.size() == PHYS_REGS);
            if (can_pop) since.push_back(fq.pop_front());
            if (rv && ra != 0) begin
                if (is_full) begin
                    m_err = 1'b1;
                end else begin
                    fq.push_back(ra);
                    if (fq.size() + since.size() > PHYS_REGS)
                        dirty = 1'b1;
                end
            end
            if (rs) begin
                fq = {since, fq};
                since.delete();
                dirty = 1'b0;
            end else if (ck) begin
                since.delete();
                dirty = 1'b0;
            end
        end
        e.done  = m_run;
        e.valid = m_run && (fq.size() != 0);
        e.addr  = e.valid ? fq[0] : 0;
        e.count = m_run ? fq.size() : 0;
        e.err   = m_err;
        exp_q.push_back(e);
    endtask

    task automatic cycle(input bit a, input bit rv,
                         input int ra, input bit ck,
                         input bit rs);
        @(negedge clk);
        step_now(a, rv, ra, ck, rs);
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_init_done"}, init_done, 0);
        chk({tag, "_alloc_valid"}, alloc_valid, 0);
        chk({tag, "_free_count"}, free_count, 0);
        chk({tag, "_err"}, err, 0);
    endtask

    task automatic release_reset();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        step_now(0, 0, 0, 0, 0);
        repeat (INIT_CNT - 1) cycle(0, 0, 0, 0, 0);
    endtask

    // Monitor: compare DUT outputs after each edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("sb_init_done", init_done, e.done);
                chk("sb_alloc_valid", alloc_valid, e.valid);
                chk("sb_free_count", free_count, e.count);
                chk("sb_err", err, e.err);
                if (e.valid)
                    chk("sb_alloc_addr", alloc_addr, e.addr);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        bit a, rv, ck, rs;
        int ra, pa, pr;

        reset     = 1'b1;
        alloc_req = 1'b0;
        rel_valid = 1'b0;
        rel_addr  = '0;
        ckpt      = 1'b0;
        restore   = 1'b0;
        #3 reset = 1'b0;
        #1 chk_reset("por");
        m_reset();

        release_reset();
        settle();
        chk("init_done_96", init_done, 1);
        chk("init_alloc_addr", alloc_addr, 32);
        chk("init_free_count", free_count, 96);

        repeat (3) cycle(1, 0, 0, 0, 0);
        settle();
        chk("after3_free_count", free_count, 93);
        chk("after3_alloc_addr", alloc_addr, 35);

        cycle(0, 1, 5, 0, 0);
        repeat (7) cycle(1, 0, 0, 0, 0);
        cycle(0, 0, 0, 1, 0);
        repeat (4) cycle(1, 0, 0, 0, 0);
        cycle(0, 1, 77, 0, 1);
        settle();
        chk("restore_alloc_addr", alloc_addr, 42);
        chk("restore_free_count", free_count, 88);

        cycle(0, 1, 0, 0, 0);
        settle();
        chk("x0_free_count", free_count, 88);
        chk("x0_err", err, 0);

        repeat (86) cycle(1, 0, 0, 0, 0);
        settle();
        chk("wrap_alloc_addr", alloc_addr, 5);
        repeat (2) cycle(1, 0, 0, 0, 0);
        settle();
        chk("drained_valid", alloc_valid, 0);
        chk("drained_count", free_count, 0);

        cycle(1, 1, 40, 0, 0);
        settle();
        chk("nobypass_count", free_count, 1);
        chk("nobypass_valid", alloc_valid, 1);
        chk("nobypass_addr", alloc_addr, 40);
        cycle(1, 0, 0, 0, 0);
        settle();
        chk("grant40_count", free_count, 0);

        cycle(0, 0, 0, 1, 0);
        for (int i = 0; i < PHYS_REGS; i++)
            cycle(0, 1, (i % 127) + 1, 0, 0);
        settle();
        chk("full_count", free_count, PHYS_REGS);
        chk("full_err_clear", err, 0);
        cycle(0, 1, 9, 0, 0);
        settle();
        chk("overfull_err", err, 1);
        chk("overfull_count", free_count, PHYS_REGS);

        for (int i = 0; i < 1600; i++) begin
            pa = (i < 800) ? 60 : 35;
            pr = (i < 800) ? 35 : 60;
            a  = $urandom_range(99) < pa;
            rv = $urandom_range(99) < pr;
            ra = ($urandom_range(19) == 0)
                 ? 0 : $urandom_range(PHYS_REGS - 1, 1);
            ck = $urandom_range(9) == 0;
            rs = !dirty && ($urandom_range(19) == 0)
                 && (fq.size() + since.size() + 1 <= PHYS_REGS);
            cycle(a, rv, ra, ck, rs);
        end

        for (int i = 0; i < 400 && fq.size() != 50; i++) begin
            if (fq.size() > 50) cycle(1, 0, 0, 0, 0);
            else cycle(0, 1, $urandom_range(PHYS_REGS - 1, 1), 0, 0);
        end
        settle();
        chk("pre_reset_count", free_count, 50);

        alloc_req = 1'b0;
        rel_valid = 1'b0;
        ckpt      = 1'b0;
        restore   = 1'b0;
        reset     = 1'b0;
        #1 chk_reset("mid");
        m_reset();

        repeat (2) @(negedge clk);
        reset = 1'b1;
        step_now(0, 0, 0, 0, 0);
        for (int i = 1; i < INIT_CNT; i++)
            cycle(0, i == 10, 3, 0, 0);
        settle();
        chk("rerun_alloc_addr", alloc_addr, 32);
        chk("rerun_free_count", free_count, 96);
        chk("init_rel_err", err, 1);

        cycle(0, 0, 0, 0, 0);
        settle();
        chk("err_sticky", err, 1);
        reset = 1'b0;
        #1 chk("err_cleared", err, 0);

        $display("Result: errors=%0d of %0d checks",
                 errors, checks);
        $finish;
    end

endmodule

// File: doc/free_list.md
FREE_LIST -- requirements
Module: free_list

Interface
REQ-001 Parameter: PHYS_REGS, default 128, number of physical registers.
REQ-002 Parameter: ARCH_REGS, default 32, number of architectural registers, identity-mapped at reset (p0..p31).
REQ-003 Parameter: PADDR_W, default 7, physical address width (log2 PHYS_REGS).
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 init_done  output  1  high once the free-list contents are initialised.
REQ-007 alloc_req  input  1  rename stage requests one free physical register this cycle.
REQ-008 alloc_valid  output  1  a free address is available on alloc_addr.
REQ-009 alloc_addr  output  PADDR_W  head entry, first-word fall-through; feeds the rename table's free_phy_addr.
REQ-010 rel_valid  input  1  one physical register is returned this cycle.
REQ-011 rel_addr  input  PADDR_W  returned address; this is the old mapping emitted by the rename table.
REQ-012 ckpt  input  1  snapshot the head pointer; issued on a branch rename.
REQ-013 restore  input  1  rewind the head to the snapshot; issued on a mispredict.
REQ-014 free_count  output  PADDR_W+1  number of free entries.
REQ-015 err  output  1  sticky protocol-error flag.

Function
REQ-016 Storage is a circular buffer of PHYS_REGS entries, PADDR_W bits wide, with head and tail pointers each PADDR_W+1 bits (MSB is the wrap bit).
REQ-017 FSM has states INIT and RUN; reset enters INIT with idx=0.
REQ-018 INIT: each cycle write entry[idx]=ARCH_REGS+idx and increment idx; after PHYS_REGS-ARCH_REGS writes (96 cycles), go to RUN with head=0 and tail=96.
REQ-019 In INIT: alloc_valid=0 and init_done=0; alloc_req, rel_valid, ckpt and restore are ignored, and any of them asserted sets err.
REQ-020 In RUN: init_done=1, alloc_valid=(free_count!=0), alloc_addr=entry[head[PADDR_W-1:0]].
REQ-021 Pop occurs when alloc_req and alloc_valid are both high and restore is low; head increments by 1 and wraps modulo 2*PHYS_REGS.
REQ-022 alloc_req with alloc_valid low has no effect; the requester stalls, and err is not set.
REQ-023 Push occurs when rel_valid is high and rel_addr!=0: write entry[tail] and increment tail; rel_addr==0 (x0 mapping) is silently dropped.
REQ-024 Push when free_count==PHYS_REGS is dropped and sets err.
REQ-025 Simultaneous push and pop is legal; free_count is unchanged.
REQ-026 No same-cycle bypass: a release into an empty list becomes allocatable on the next cycle.
REQ-027 ckpt saves the head value as it stands after this cycle's pop; a later ckpt overwrites the snapshot (single level).
REQ-028 restore sets head to the snapshot and suppresses that cycle's pop; a same-cycle push still occurs.
REQ-029 ckpt and restore asserted in the same cycle: restore wins and the snapshot is unchanged.
REQ-030 free_count = tail - head (modulo arithmetic on PADDR_W+1 bits), registered and updated with the pointers.
REQ-031 err is cleared only by reset.

Reset
REQ-032 Reset asserted: state=INIT, idx=0, head=0, tail=0, snapshot=0, free_count=0, alloc_valid=0, init_done=0, err=0; all effective immediately, without a clock edge.
REQ-033 Reset asserted mid-RUN discards all contents, and the INIT sequence reruns after reset is deasserted.
REQ-034 Buffer contents are not reset; they are rewritten by INIT.

Structure
REQ-035 PHYS_REGS, ARCH_REGS, PADDR_W and the FSM state enum live in the shared package rename_pkg, alongside the rename-table constants.
REQ-036 Storage is the sub-module free_list_ram: one write port, one asynchronous read port, no reset.
REQ-037 Pointers, the FSM, the snapshot and the error logic live in free_list; expected size is 150-300 lines.

Verification
REQ-038 Release reset, wait -> init_done rises exactly 96 cycles later; alloc_addr=32, free_count=96.
REQ-039 Hold alloc_req for 3 cycles -> addresses 32, 33, 34 are granted; free_count=93; a push of rel_addr=5 then appears at the tail after address 127.
REQ-040 Drain all 96 entries -> alloc_valid=0; push 40 and pop in the same cycle -> no grant that cycle, 40 granted the next cycle.
REQ-041 ckpt at head=10, pop 4, restore with a simultaneous push of 77 -> head=10, alloc_addr=42, free_count increases by 4+1.
REQ-042 Push rel_addr=0 -> free_count unchanged and err=0; rel_valid during INIT -> err=1, cleared only by reset.
REQ-043 Assert reset mid-RUN with free_count=50 -> outputs are at reset values without a clock edge; after deassertion INIT reruns and alloc_addr=32.
